// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout and skid-stage state encodings.
package pipe_stage_reg_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [5:0] alu_control;
        logic       store_enable;
        logic [5:0] branch_kind;   // one-hot: beq, bne, blt, bge, bltu, bgeu
        logic       jump;
        logic       jalr;
        logic       lui;
        logic       load_signed;
        logic [1:0] mem_size;
        logic       alu_src;
        logic [1:0] rsvd;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Encoded as {skid_valid, main_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid + ctrl + data with load/drop/clear; ctrl reads zero when empty.
// Latency 1 cycle from load; no flow control of its own, the parent decides load/drop.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Data is left in place on drop; only reset or clear wipe the payload.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= d_ctrl;
            data_r  <= d_data;
        end else if (drop) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end
    end

    assign q_valid = valid_r;
    assign q_ctrl  = valid_r ? ctrl_r : '0;
    assign q_data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (plain or 2-entry skid) with flush, bubble ctrl gating and stall counter.
// Latency 1 cycle; SKID=0 passes out_ready through to in_ready, SKID=1 drives in_ready from a register.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = pipe_stage_reg_pkg::CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_stats
);

    logic              main_valid;
    logic              main_load;
    logic              main_drop;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_xfer;
    logic              out_xfer;

    // A transfer offered during flush is swallowed, never captured.
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = main_valid && out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .load    (main_load),
        .drop    (main_drop),
        .d_ctrl  (main_d_ctrl),
        .d_data  (main_d_data),
        .q_valid (main_valid),
        .q_ctrl  (main_ctrl),
        .q_data  (main_data)
    );

    generate
        if (SKID == 0) begin : g_reg
            assign in_ready    = !main_valid || out_ready;
            assign main_load   = in_xfer;
            assign main_drop   = out_xfer;
            assign main_d_ctrl = in_ctrl;
            assign main_d_data = in_data;
        end else begin : g_skid
            logic              skid_valid;
            logic              skid_load;
            logic              skid_drop;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic [1:0]        state;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .load    (skid_load),
                .drop    (skid_drop),
                .d_ctrl  (in_ctrl),
                .d_data  (in_data),
                .q_valid (skid_valid),
                .q_ctrl  (skid_ctrl),
                .q_data  (skid_data)
            );

            assign in_ready = !skid_valid;
            assign state    = {skid_valid, main_valid};

            always_comb begin
                main_load   = 1'b0;
                main_drop   = 1'b0;
                skid_load   = 1'b0;
                skid_drop   = 1'b0;
                main_d_ctrl = in_ctrl;
                main_d_data = in_data;
                case (state)
                    ST_EMPTY: main_load = in_xfer;
                    ST_ONE: begin
                        if (out_xfer) begin
                            main_load = in_xfer;
                            main_drop = !in_xfer;
                        end else begin
                            skid_load = in_xfer;
                        end
                    end
                    ST_FULL: begin
                        // Skid entry slides into main on the same edge the head leaves.
                        if (out_xfer) begin
                            main_load   = 1'b1;
                            skid_drop   = 1'b1;
                            main_d_ctrl = skid_ctrl;
                            main_d_data = skid_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_r;

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            stall_r <= '0;
        end else if (main_valid && !out_ready && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_ONE;
        end
    end

    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid stage, a plain stage and a 4-bit-counter skid stage in parallel against a FIFO model.
module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int CW = 24;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, clr_stats;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic [2:0]    o_rdy, o_vld;
    logic [CW-1:0] o_ctrl [3];
    logic [DW-1:0] o_data [3];
    logic [15:0]   scnt0, scnt1;
    logic [3:0]    scnt2;

    int n_checks = 0;
    int n_errors = 0;

    ent_t mq [3][2];
    int   occ [3];
    int   mcnt [3];
    int   cap_skid [3] = '{1, 0, 1};
    int   cnt_max [3]  = '{65535, 65535, 15};

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_vld[0]), .out_ready(out_ready),
        .out_ctrl(o_ctrl[0]), .out_data(o_data[0]), .stall_cnt(scnt0), .clr_stats(clr_stats)
    );

    pipe_stage_reg #(.SKID(0)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_vld[1]), .out_ready(out_ready),
        .out_ctrl(o_ctrl[1]), .out_data(o_data[1]), .stall_cnt(scnt1), .clr_stats(clr_stats)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_vld[2]), .out_ready(out_ready),
        .out_ctrl(o_ctrl[2]), .out_data(o_data[2]), .stall_cnt(scnt2), .clr_stats(clr_stats)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_scnt(input int k);
        case (k)
            0:       return scnt0;
            1:       return scnt1;
            default: return {12'd0, scnt2};
        endcase
    endfunction

    // Skid stage holds up to two entries and ignores out_ready for in_ready; plain stage holds one.
    function automatic logic exp_rdy(input int k);
        if (cap_skid[k] != 0) return occ[k] < 2;
        return (occ[k] == 0) || out_ready;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d in_ready", k), o_rdy[k], exp_rdy(k));
            chk($sformatf("u%0d out_valid", k), o_vld[k], occ[k] > 0);
            chk($sformatf("u%0d out_ctrl", k), o_ctrl[k], (occ[k] > 0) ? mq[k][0].c : '0);
            if (occ[k] > 0) chk($sformatf("u%0d out_data", k), o_data[k], mq[k][0].d);
            chk($sformatf("u%0d stall_cnt", k), obs_scnt(k), mcnt[k]);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic ix, ox;
            ix = in_valid && exp_rdy(k);
            ox = (occ[k] > 0) && out_ready;
            if (rst) begin
                occ[k]  = 0;
                mcnt[k] = 0;
            end else begin
                if (clr_stats) mcnt[k] = 0;
                else if (occ[k] > 0 && !out_ready && mcnt[k] < cnt_max[k]) mcnt[k]++;
                if (flush) begin
                    occ[k] = 0;
                end else begin
                    if (ox) begin
                        mq[k][0] = mq[k][1];
                        occ[k]--;
                    end
                    if (ix) begin
                        mq[k][occ[k]] = {in_ctrl, in_data};
                        occ[k]++;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        rst = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic offer(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = CW'(24'hA50000) | CW'(d[15:0]);
        in_data  = d;
        cycle();
    endtask

    initial begin
        logic [DW-1:0] got[$];
        logic [DW-1:0] expv [3];
        int n_out;
        int seen;

        rst = 1'b1; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        for (int k = 0; k < 3; k++) begin
            occ[k] = 0;
            mcnt[k] = 0;
        end
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        chk("reset out_valid", o_vld, 3'b000);
        chk("reset in_ready", o_rdy, 3'b111);

        // First transfer appears one cycle later
        out_ready = 1'b1;
        offer(128'h11);
        in_valid = 1'b0;
        chk("first out_valid u0", o_vld[0], 1'b1);
        chk("first out_data u0", o_data[0], 128'h11);
        chk("first out_data u1", o_data[1], 128'h11);

        // Skid fill: A, B accepted, C held off until downstream drains
        idle_drain();
        out_ready = 1'b0;
        offer(128'hA);
        chk("skid rdy after A", o_rdy[0], 1'b1);
        offer(128'hB);
        chk("skid rdy after B", o_rdy[0], 1'b0);
        offer(128'hC);
        chk("skid rdy holding C", o_rdy[0], 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic take;
            if (o_vld[0]) got.push_back(o_data[0]);
            take = in_valid && o_rdy[0];
            cycle();
            if (take) in_valid = 1'b0;
        end
        expv = '{128'hA, 128'hB, 128'hC};
        chk("skid order count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("skid order %0d", i), (i < got.size()) ? got[i] : '0, expv[i]);

        // Flush while full with a concurrent offer
        idle_drain();
        out_ready = 1'b0;
        offer(128'h21);
        offer(128'h22);
        chk("full before flush", o_rdy[0], 1'b0);
        flush = 1'b1;
        offer(128'hDEAD);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", o_vld, 3'b000);
        chk("flush out_ctrl u0", o_ctrl[0], '0);
        chk("flush in_ready u0", o_rdy[0], 1'b1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_vld[0]) seen++;
            cycle();
        end
        chk("flushed entry reappeared", seen, 0);

        // Stall counter saturation and clear
        idle_drain();
        out_ready = 1'b0;
        offer(128'h31);
        in_valid = 1'b0;
        repeat (20) cycle();
        chk("stall saturate u2", scnt2, 4'd15);
        clr_stats = 1'b1;
        cycle();
        clr_stats = 1'b0;
        chk("stall clear u2", scnt2, 4'd0);
        chk("stall clear u0", scnt0, 16'd0);

        // Plain register streams one per cycle with no bubble
        idle_drain();
        out_ready = 1'b0;
        offer(128'h100);
        out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 128'h101 + DW'(i);
            if (o_vld[1]) begin
                n_out++;
                chk($sformatf("stream data %0d", i), o_data[1], 128'h100 + DW'(i));
            end
            cycle();
        end
        chk("stream count u1", n_out, 10);

        // Reset while full
        idle_drain();
        out_ready = 1'b0;
        offer(128'h41);
        offer(128'h42);
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst full out_valid", o_vld[0], 1'b0);
        chk("rst full stall_cnt", scnt0, 16'd0);
        chk("rst full in_ready", o_rdy[0], 1'b1);

        // Random traffic with occasional flush, clear and reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) < 55);
            flush     = ($urandom_range(99) < 3);
            clr_stats = ($urandom_range(99) < 2);
            rst       = ($urandom_range(999) < 5);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, meaning payload bits that are zeroed only by reset or flush.
REQ-002 Parameter CTRL_W, default 24, meaning control bits that are forced to zero whenever the stage holds a bubble.
REQ-003 Parameter SKID, default 1, meaning 0 selects a single register and 1 selects a two-entry skid buffer.
REQ-004 Parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-005 Port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-007 Port flush  input  1  meaning a synchronous kill of every held entry and of any incoming transfer.
REQ-008 Port in_valid  input  1  meaning the upstream entry is valid.
REQ-009 Port in_ready  output  1  meaning the stage accepts an entry this cycle.
REQ-010 Port in_ctrl  input  CTRL_W  meaning the upstream control bundle.
REQ-011 Port in_data  input  DATA_W  meaning the upstream data bundle (PC, operands, immediate, register indices).
REQ-012 Port out_valid  output  1  meaning the head entry is valid.
REQ-013 Port out_ready  input  1  meaning downstream consumes the head this cycle.
REQ-014 Port out_ctrl  output  CTRL_W  meaning the head control bundle.
REQ-015 Port out_data  output  DATA_W  meaning the head data bundle.
REQ-016 Port stall_cnt  output  CNT_W  meaning the count of cycles with out_valid=1 and out_ready=0.
REQ-017 Port clr_stats  input  1  meaning a synchronous clear of stall_cnt.

Function
REQ-018 An input transfer SHALL occur on in_valid && in_ready, and an output transfer SHALL occur on out_valid && out_ready.
REQ-019 Latency from input transfer to out_valid SHALL be one cycle when the stage is empty.
REQ-020 With SKID=0, in_ready SHALL equal !out_valid || out_ready (combinational); one entry SHALL be held.
REQ-021 With SKID=1, in_ready SHALL equal !skid_valid (registered, with no combinational path from out_ready); states SHALL be EMPTY, ONE (main valid) and FULL (main and skid valid).
REQ-022 SKID=1 transitions: EMPTY to ONE on input transfer; ONE to FULL on input transfer without output transfer; ONE to EMPTY on output transfer without input transfer; FULL to ONE on output transfer, with skid moving into main in the same edge.
REQ-023 In the ONE state, a simultaneous input and output transfer SHALL load main directly and keep the ONE state.
REQ-024 In the FULL state, in_ready SHALL be 0 and no input SHALL be captured.
REQ-025 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-026 The held head SHALL stay stable while out_valid && !out_ready.
REQ-027 out_ctrl SHALL be all-zero whenever out_valid=0, so a bubble never asserts reg_write, store, branch or jump controls.
REQ-028 Flush SHALL clear all valid bits and zero ctrl and data in every entry at the next edge.
REQ-029 An input transfer in the flush cycle SHALL be discarded; the state after flush SHALL be EMPTY.
REQ-030 Flush SHALL take priority over all transfers; rst SHALL take priority over flush.
REQ-031 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready.
REQ-032 stall_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 clr_stats SHALL zero stall_cnt and take priority over any increment in the same cycle.
REQ-034 Flush SHALL NOT affect stall_cnt.

Reset
REQ-035 On rst, all valid bits SHALL be 0, ctrl and data SHALL be 0 in every entry, and stall_cnt SHALL be 0.
REQ-036 in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-037 Reset asserted mid-operation SHALL discard all entries with no partial transfer.

Structure
REQ-038 The ctrl field layout (reg_write, mem_to_reg, alu_control[5:0], store_enable, branch kinds, jump, jalr, lui, load sign, mem_size[1:0], alu_src) and its CTRL_W localparam SHALL live in the shared pipeline package.
REQ-039 A single sub-module pipe_slot (valid+ctrl+data register with load, clear and ctrl-gating) SHALL be instantiated once for SKID=0 and twice for SKID=1.

Verification
REQ-040 Reset then in_valid=1, in_data=0x11, out_ready=1 SHALL give out_valid=1 and out_data=0x11 on the next cycle.
REQ-041 With SKID=1 and out_ready=0, three entries 0xA, 0xB, 0xC offered back-to-back SHALL be accepted as A and B only, with in_ready=0 from cycle 2; after out_ready=1, outputs SHALL be A, B, C in order.
REQ-042 With FULL and flush=1 together with in_valid=1: the next cycle SHALL show out_valid=0, out_ctrl=0 and in_ready=1; the offered entry SHALL never appear.
REQ-043 With CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles SHALL give stall_cnt=15; clr_stats=1 SHALL give 0 on the next cycle.
REQ-044 With SKID=0 in the ONE state, in_valid=1 and out_ready=1 for 10 cycles SHALL deliver 10 entries at one per cycle with no bubble.
REQ-045 With rst asserted while FULL, the next cycle SHALL show out_valid=0, stall_cnt=0 and in_ready=1.
